// File: rtl/mult_unit.sv
// Iterative shift-add multiplier. It consumes one multiplier bit per cycle and emits a
// 2*WIDTH product with a single-cycle done pulse. Signed operands run as magnitude plus negate flag.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on acceptance
//   S_RUN  | WIDTH shift-add iterations, counter 0..WIDTH-1
//   S_DONE | result valid, done high for this one cycle
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [2*WIDTH-1:0]   w_prod_final;

    // The unsigned magnitude of -2^(W-1) is exactly 2^(W-1), so min*min needs no special case.
    assign w_mag_a = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    assign w_addend     = r_prod[0] ? r_mcand : '0;
    assign w_sum        = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_prod_next  = {w_sum, r_prod[WIDTH-1:1]};
    assign w_prod_final = r_neg ? -w_prod_next : w_prod_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_neg       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_result_lo <= '0;
            o_result_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_mcand <= w_mag_a;
                        r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_prod <= w_prod_next;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt                      <= '0;
                        {o_result_hi, o_result_lo} <= w_prod_final;
                        o_busy                     <= 1'b0;
                        o_done                     <= 1'b1;
                        r_state                    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit (WIDTH=32): latency, unsigned/signed products, reset abort,
// ignored mid-run inputs, back-to-back starts and a downstream register fed by done/result_lo.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] dst_reg;
    int           we_cnt;

    mult_unit #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_is_signed (is_signed),
        .i_a         (a),
        .i_b         (b),
        .o_busy      (busy),
        .o_done      (done),
        .o_result_lo (result_lo),
        .o_result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Destination register downstream of the multiplier: din=result_lo, we=done.
    always @(posedge clk) begin
        if (rst) begin
            dst_reg <= 32'hDEAD_BEEF;
            we_cnt  <= 0;
        end else if (done) begin
            dst_reg <= result_lo;
            we_cnt  <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
        a         = va;
        b         = vb;
        is_signed = vs;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Counts edges until done is seen (bounded), busy samples, and any result change before done.
    task automatic wait_done(output int cyc, output int busy_cyc, output bit res_chg);
        logic [63:0] r0;
        r0       = {result_hi, result_lo};
        cyc      = 0;
        busy_cyc = 0;
        res_chg  = 1'b0;
        while (!done && cyc < 80) begin
            if (busy) busy_cyc++;
            if ({result_hi, result_lo} !== r0) res_chg = 1'b1;
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        int  bcyc;
        bit  chg;
        int  pulses;
        int  t;
        int  d[3];
        int  we0;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", {result_hi, result_lo}, 64'd0);

        // 7*6 unsigned: latency, busy width, single-cycle done
        launch(32'd7, 32'd6, 1'b0);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done(cyc, bcyc, chg);
        check("t1_latency", 64'(cyc), 64'd32);
        check("t1_busy_cycles", 64'(bcyc), 64'd32);
        check("t1_busy_at_done", 64'(busy), 64'd0);
        check("t1_result", {result_hi, result_lo}, 64'h0000_0000_0000_002A);
        tick();
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_result_hold", {result_hi, result_lo}, 64'h0000_0000_0000_002A);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc, bcyc, chg);
        check("t2_latency", 64'(cyc), 64'd32);
        check("t2_max_unsigned", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
        tick();

        launch(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(cyc, bcyc, chg);
        check("t3_neg3_x5", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        tick();

        launch(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(cyc, bcyc, chg);
        check("t3_min_x_min", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
        tick();

        launch(32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(cyc, bcyc, chg);
        check("t3_neg1_x2", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();

        launch(32'd0, 32'h0000_1234, 1'b0);
        wait_done(cyc, bcyc, chg);
        check("zero_latency", 64'(cyc), 64'd32);
        check("zero_result", {result_hi, result_lo}, 64'd0);
        tick();

        // Load a nonzero result so the reset clear is observable, then abort mid-run
        launch(32'h0000_1234, 32'h0000_5678, 1'b0);
        wait_done(cyc, bcyc, chg);
        check("t4_pre_result", {result_hi, result_lo}, 64'h0000_0000_0626_0060);
        tick();
        launch(32'h0000_1234, 32'h0000_5678, 1'b0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_done", 64'(done), 64'd0);
        check("t4_rst_result", {result_hi, result_lo}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        check("t4_no_done_after_abort", 64'(pulses), 64'd0);
        launch(32'd3, 32'd4, 1'b0);
        wait_done(cyc, bcyc, chg);
        check("t4_fresh_3x4", {result_hi, result_lo}, 64'd12);
        tick();

        // Mid-run operand changes and a start pulse must be ignored
        launch(32'd100, 32'd3, 1'b0);
        repeat (5) tick();
        a = 32'hFFFF_FFF0; b = 32'h8000_0001; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bcyc, chg);
        check("t5_latency_unchanged", 64'(cyc), 64'd26);
        check("t5_no_result_change_in_run", 64'(chg), 64'd0);
        check("t5_latched_operands", {result_hi, result_lo}, 64'd300);
        tick();
        check("t5_no_queued_op", 64'(busy), 64'd0);

        // start held high: one done per 34 cycles
        a = 32'd5; b = 32'd7; is_signed = 1'b0; start = 1'b1;
        pulses = 0; t = 0;
        while (pulses < 3 && t < 200) begin
            tick();
            t++;
            if (done) begin
                d[pulses] = t;
                pulses++;
            end
        end
        start = 1'b0;
        check("t5_pulse_count", 64'(pulses), 64'd3);
        check("t5_spacing_1", 64'(d[1] - d[0]), 64'd34);
        check("t5_spacing_2", 64'(d[2] - d[1]), 64'd34);
        check("t5_held_result", {result_hi, result_lo}, 64'd35);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        check("t5_no_extra_pulse", 64'(pulses), 64'd0);

        // Downstream register written exactly once
        we0 = we_cnt;
        launch(32'd9, 32'd9, 1'b0);
        wait_done(cyc, bcyc, chg);
        check("t6_reg_before_done_edge", 64'(dst_reg), 64'd35);
        check("t6_we_before_done_edge", 64'(we_cnt - we0), 64'd0);
        tick();
        check("t6_reg_after_done_edge", 64'(dst_reg), 64'h51);
        check("t6_we_once", 64'(we_cnt - we0), 64'd1);
        repeat (5) tick();
        check("t6_reg_stable", 64'(dst_reg), 64'h51);
        check("t6_we_still_once", 64'(we_cnt - we0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
